// File: rtl/user_dma_wr_psg.sv
// Write-path packet stream generator: buffers a 128-bit user stream in a FWFT FIFO
// and offers it to the DMA arbitrator as address/length bursts until the transfer is done.
//
// state   | meaning
// S_IDLE  | no transfer; waiting for i_start
// S_FILL  | collecting beats until the FIFO holds the next burst
// S_AVAIL | burst offered to the arbitrator; popping beats until i_dma_done
module user_dma_wr_psg #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 128,
  parameter int DMA_LEN     = 5,
  parameter int BURST_BEATS = 8,
  parameter int XFER_WIDTH  = 20,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [XFER_WIDTH-1:0] i_xfer_len,
  output logic                  o_busy,
  output logic                  o_xfer_done,
  input  logic                  i_user_data_valid,
  input  logic [DATA_WIDTH-1:0] i_user_data,
  output logic                  o_user_data_rdy,
  output logic                  o_dma_data_avail,
  output logic [ADDR_WIDTH-1:0] o_dma_wr_addr,
  output logic [DMA_LEN-1:0]    o_dma_wr_len,
  input  logic                  i_dma_data_rd,
  output logic [DATA_WIDTH-1:0] o_dma_data,
  input  logic                  i_dma_done
);

  localparam int BW = XFER_WIDTH - 4;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [BW-1:0] BURST_MAX = BW'(BURST_BEATS);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_AVAIL} state_t;

  state_t r_state, w_state_nxt;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [BW-1:0]         r_rem_beats;
  logic [BW-1:0]         r_total_beats;
  logic [BW-1:0]         r_acc_beats;
  logic [BW-1:0]         r_burst_len;
  logic [BW-1:0]         r_rd_cnt;
  logic                  r_busy;
  logic                  r_xfer_done;
  logic                  r_avail;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DMA_LEN-1:0]    r_wr_len;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;

  logic [BW-1:0]         w_start_beats;
  logic [BW-1:0]         w_rem_after;
  logic [ADDR_WIDTH-1:0] w_addr_step;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_rdy;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_unused;

  function automatic logic [BW-1:0] clip_burst(input logic [BW-1:0] beats);
    return (beats > BURST_MAX) ? BURST_MAX : beats;
  endfunction

  assign w_start_beats = i_xfer_len[XFER_WIDTH-1:4];
  assign w_unused      = ^i_xfer_len[3:0];
  assign w_rem_after   = r_rem_beats - r_burst_len;
  assign w_addr_step   = ADDR_WIDTH'({r_burst_len, 4'b0000});
  assign w_empty       = (r_count == '0);
  assign w_full        = (r_count == CW'(FIFO_DEPTH));
  assign w_rdy         = r_busy && !w_full && (r_acc_beats < r_total_beats);
  assign w_push        = i_user_data_valid && w_rdy;
  // Reads past the burst length or on an empty FIFO are dropped here.
  assign w_pop         = (r_state == S_AVAIL) && i_dma_data_rd &&
                         (r_rd_cnt < r_burst_len) && !w_empty;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start && (w_start_beats != '0)) w_state_nxt = S_FILL;
      S_FILL:  if (BW'(r_count) >= r_burst_len) w_state_nxt = S_AVAIL;
      S_AVAIL: if (i_dma_done) w_state_nxt = (w_rem_after == '0) ? S_IDLE : S_FILL;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_addr        <= '0;
      r_rem_beats   <= '0;
      r_total_beats <= '0;
      r_acc_beats   <= '0;
      r_burst_len   <= '0;
      r_rd_cnt      <= '0;
      r_busy        <= 1'b0;
      r_xfer_done   <= 1'b0;
      r_avail       <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_len      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_xfer_done <= 1'b0;
      if (w_push) r_acc_beats <= r_acc_beats + BW'(1);
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (w_start_beats == '0) begin
              r_xfer_done <= 1'b1;
            end else begin
              r_addr        <= i_base_addr;
              r_rem_beats   <= w_start_beats;
              r_total_beats <= w_start_beats;
              r_acc_beats   <= '0;
              r_burst_len   <= clip_burst(w_start_beats);
              r_rd_cnt      <= '0;
              r_busy        <= 1'b1;
            end
          end
        end
        S_FILL: begin
          if (w_state_nxt == S_AVAIL) begin
            r_avail   <= 1'b1;
            r_wr_addr <= r_addr;
            r_wr_len  <= r_burst_len[DMA_LEN-1:0];
          end
        end
        S_AVAIL: begin
          if (w_pop) r_rd_cnt <= r_rd_cnt + BW'(1);
          // A pop in the done cycle is still applied to the FIFO; the counter just restarts.
          if (i_dma_done) begin
            r_avail     <= 1'b0;
            r_addr      <= r_addr + w_addr_step;
            r_rem_beats <= w_rem_after;
            r_burst_len <= clip_burst(w_rem_after);
            r_rd_cnt    <= '0;
            if (w_rem_after == '0) begin
              r_busy      <= 1'b0;
              r_xfer_done <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_user_data;
  end

  assign o_busy           = r_busy;
  assign o_xfer_done      = r_xfer_done;
  assign o_user_data_rdy  = w_rdy;
  assign o_dma_data_avail = r_avail;
  assign o_dma_wr_addr    = r_wr_addr;
  assign o_dma_wr_len     = r_wr_len;
  assign o_dma_data       = w_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: tb/tb_user_dma_wr_psg.sv
// Bench for user_dma_wr_psg: user beats are queued as expected data when accepted and
// checked when the arbitrator side reads them; burst address/length checked on each offer.
module tb_user_dma_wr_psg;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic         i_start;
  logic [31:0]  i_base_addr;
  logic [19:0]  i_xfer_len;
  logic         o_busy;
  logic         o_xfer_done;
  logic         i_user_data_valid;
  logic [127:0] i_user_data;
  logic         o_user_data_rdy;
  logic         o_dma_data_avail;
  logic [31:0]  o_dma_wr_addr;
  logic [4:0]   o_dma_wr_len;
  logic         i_dma_data_rd;
  logic [127:0] o_dma_data;
  logic         i_dma_done;

  int errors = 0;
  int checks = 0;
  int feed_left = 0;
  logic [31:0] seq = 32'd0;
  logic [127:0] exp_q[$];

  user_dma_wr_psg dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_xfer_len(i_xfer_len), .o_busy(o_busy), .o_xfer_done(o_xfer_done),
    .i_user_data_valid(i_user_data_valid), .i_user_data(i_user_data),
    .o_user_data_rdy(o_user_data_rdy), .o_dma_data_avail(o_dma_data_avail),
    .o_dma_wr_addr(o_dma_wr_addr), .o_dma_wr_len(o_dma_wr_len),
    .i_dma_data_rd(i_dma_data_rd), .o_dma_data(o_dma_data), .i_dma_done(i_dma_done)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to the next falling edge and run the user-side feeder for the coming rising edge.
  task automatic tick();
    @(negedge i_clk);
    if (feed_left > 0) begin
      i_user_data_valid = 1'b1;
      i_user_data = {seq, ~seq, seq * 32'd3, 32'hC0DE0000 ^ seq};
      if (o_user_data_rdy) begin
        exp_q.push_back(i_user_data);
        seq = seq + 32'd1;
        feed_left--;
      end
    end else begin
      i_user_data_valid = 1'b0;
    end
  endtask

  task automatic start_xfer(input logic [31:0] base, input logic [19:0] len);
    i_base_addr = base;
    i_xfer_len  = len;
    i_start     = 1'b1;
    feed_left   = int'(len >> 4);
    tick();
    i_start = 1'b0;
    checks++;
    if (o_busy !== 1'b1) begin errors++; $display("FAIL start_busy: got %b expected 1", o_busy); end
  endtask

  task automatic do_burst(input logic [31:0] exp_addr, input logic [4:0] exp_len,
                          input int nreads, input bit last);
    int w;
    logic [127:0] exp_d;
    w = 0;
    while (!o_dma_data_avail && w < 300) begin tick(); w++; end
    checks++;
    if (o_dma_data_avail !== 1'b1) begin
      errors++; $display("FAIL avail_timeout: got %b expected 1 (addr %h)", o_dma_data_avail, exp_addr);
      return;
    end
    checks++;
    if (o_dma_wr_addr !== exp_addr) begin errors++; $display("FAIL burst_addr: got %h expected %h", o_dma_wr_addr, exp_addr); end
    checks++;
    if (o_dma_wr_len !== exp_len) begin errors++; $display("FAIL burst_len: got %0d expected %0d", o_dma_wr_len, exp_len); end
    for (int k = 0; k < nreads; k++) begin
      i_dma_data_rd = 1'b1;
      if (k < int'(exp_len)) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL read_data: got %h expected <queued beat> (queue empty)", o_dma_data);
        end else begin
          exp_d = exp_q.pop_front();
          if (o_dma_data !== exp_d) begin errors++; $display("FAIL read_data: got %h expected %h", o_dma_data, exp_d); end
        end
      end
      tick();
    end
    i_dma_data_rd = 1'b0;
    if (nreads > int'(exp_len)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL extra_read_head: got %h expected <next beat> (queue empty)", o_dma_data);
      end else if (o_dma_data !== exp_q[0]) begin
        errors++; $display("FAIL extra_read_head: got %h expected %h", o_dma_data, exp_q[0]);
      end
      checks++;
      if (o_dma_data_avail !== 1'b1) begin errors++; $display("FAIL avail_hold: got %b expected 1", o_dma_data_avail); end
    end
    i_dma_done = 1'b1;
    tick();
    i_dma_done = 1'b0;
    checks++;
    if (o_dma_data_avail !== 1'b0) begin errors++; $display("FAIL avail_drop: got %b expected 0", o_dma_data_avail); end
    checks++;
    if (o_xfer_done !== last) begin errors++; $display("FAIL xfer_done: got %b expected %b", o_xfer_done, last); end
    checks++;
    if (o_busy !== !last) begin errors++; $display("FAIL busy_after_done: got %b expected %b", o_busy, !last); end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_start = 1'b0; i_base_addr = '0; i_xfer_len = '0;
    i_user_data_valid = 1'b0; i_user_data = '0; i_dma_data_rd = 1'b0; i_dma_done = 1'b0;
    tick(); tick();
    checks++;
    if ({o_busy, o_xfer_done, o_user_data_rdy, o_dma_data_avail, o_dma_wr_addr, o_dma_wr_len, o_dma_data} !== '0) begin
      errors++; $display("FAIL reset_outputs: got busy=%b done=%b rdy=%b avail=%b addr=%h len=%0d expected all 0",
                         o_busy, o_xfer_done, o_user_data_rdy, o_dma_data_avail, o_dma_wr_addr, o_dma_wr_len);
    end
    i_rst_n = 1'b1;
    feed_left = 3;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (o_user_data_rdy !== 1'b0) begin errors++; $display("FAIL idle_rdy: got %b expected 0", o_user_data_rdy); end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL idle_accept: got %0d beats expected 0", exp_q.size()); end
    feed_left = 0;
    tick();
  endtask

  task automatic test_zero_len();
    i_base_addr = 32'h0000_7000; i_xfer_len = 20'd0; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    checks++;
    if (o_xfer_done !== 1'b1) begin errors++; $display("FAIL zero_len_done: got %b expected 1", o_xfer_done); end
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL zero_len_busy: got %b expected 0", o_busy); end
    tick();
    checks++;
    if (o_xfer_done !== 1'b0) begin errors++; $display("FAIL zero_len_pulse: got %b expected 0", o_xfer_done); end
  endtask

  task automatic test_single_burst();
    start_xfer(32'h0000_1000, 20'd128);
    do_burst(32'h0000_1000, 5'd8, 8, 1'b1);
    tick();
    checks++;
    if (o_xfer_done !== 1'b0) begin errors++; $display("FAIL single_done_pulse: got %b expected 0", o_xfer_done); end
  endtask

  task automatic test_multi_burst();
    int w;
    start_xfer(32'h0000_2000, 20'd400);
    do_burst(32'h0000_2000, 5'd8, 8, 1'b0);
    do_burst(32'h0000_2080, 5'd8, 8, 1'b0);
    do_burst(32'h0000_2100, 5'd8, 8, 1'b0);
    w = 0;
    while (!o_dma_data_avail && w < 300) begin tick(); w++; end
    checks++;
    if (o_user_data_rdy !== 1'b0) begin errors++; $display("FAIL multi_rdy_after_25: got %b expected 0", o_user_data_rdy); end
    do_burst(32'h0000_2180, 5'd1, 1, 1'b1);
  endtask

  task automatic test_backpressure();
    int w;
    start_xfer(32'h0000_3000, 20'd256);
    w = 0;
    while (feed_left > 0 && w < 300) begin tick(); w++; end
    tick(); tick();
    checks++;
    if (o_user_data_rdy !== 1'b0) begin errors++; $display("FAIL bp_rdy_full: got %b expected 0", o_user_data_rdy); end
    checks++;
    if (exp_q.size() != 16) begin errors++; $display("FAIL bp_accepted: got %0d beats expected 16", exp_q.size()); end
    do_burst(32'h0000_3000, 5'd8, 8, 1'b0);
    tick();
    checks++;
    if (o_dma_data_avail !== 1'b1) begin errors++; $display("FAIL bp_second_avail: got %b expected 1", o_dma_data_avail); end
    do_burst(32'h0000_3080, 5'd8, 8, 1'b1);
  endtask

  task automatic test_extra_reads();
    start_xfer(32'h0000_6000, 20'd256);
    do_burst(32'h0000_6000, 5'd8, 10, 1'b0);
    do_burst(32'h0000_6080, 5'd8, 8, 1'b1);
  endtask

  task automatic test_mid_reset();
    logic [127:0] exp_d;
    start_xfer(32'h0000_4000, 20'd128);
    for (int w = 0; w < 300 && !o_dma_data_avail; w++) tick();
    for (int k = 0; k < 3; k++) begin
      i_dma_data_rd = 1'b1;
      checks++;
      exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      if (o_dma_data !== exp_d) begin errors++; $display("FAIL mid_read: got %h expected %h", o_dma_data, exp_d); end
      tick();
    end
    i_dma_data_rd = 1'b0;
    i_rst_n = 1'b0;
    feed_left = 0;
    tick();
    checks++;
    if ({o_busy, o_xfer_done, o_user_data_rdy, o_dma_data_avail, o_dma_wr_addr, o_dma_wr_len, o_dma_data} !== '0) begin
      errors++; $display("FAIL mid_reset_outputs: got busy=%b done=%b rdy=%b avail=%b addr=%h len=%0d data=%h expected all 0",
                         o_busy, o_xfer_done, o_user_data_rdy, o_dma_data_avail, o_dma_wr_addr, o_dma_wr_len, o_dma_data);
    end
    exp_q.delete();
    i_rst_n = 1'b1;
    tick();
    checks++;
    if (o_xfer_done !== 1'b0) begin errors++; $display("FAIL mid_reset_no_done: got %b expected 0", o_xfer_done); end
    start_xfer(32'h0000_5000, 20'd128);
    do_burst(32'h0000_5000, 5'd8, 8, 1'b1);
  endtask

  task automatic test_start_while_busy();
    start_xfer(32'h0000_3000, 20'd256);
    tick(); tick();
    i_base_addr = 32'h0000_9000; i_xfer_len = 20'd128; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    checks++;
    if (o_busy !== 1'b1) begin errors++; $display("FAIL busy_restart: got %b expected 1", o_busy); end
    do_burst(32'h0000_3000, 5'd8, 8, 1'b0);
    do_burst(32'h0000_3080, 5'd8, 8, 1'b1);
  endtask

  initial begin
    test_reset();
    test_zero_len();
    test_single_burst();
    test_multi_burst();
    test_backpressure();
    test_extra_reads();
    test_mid_reset();
    test_start_while_busy();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/user_dma_wr_psg.md
Name: user_dma_wr_psg

Overview:
- Write-path packet stream generator (PSG) sitting directly upstream of the DMA request arbitrator.
- Accepts a 128-bit user data stream into an internal FWFT FIFO and slices it into bursts.
- Presents each burst to the arbitrator's write interface as a data-available, address and length triple, then waits for done.
- Advances the host address per burst and signals completion of the whole host-programmed transfer.

Parameters:
- ADDR_WIDTH, 32, host byte address width
- DATA_WIDTH, 128, beat width (16 bytes per beat; fixed at 128 for this block)
- DMA_LEN, 5, width of the per-burst beat count
- BURST_BEATS, 8, maximum beats per burst (must be < 2^DMA_LEN)
- XFER_WIDTH, 20, width of the total transfer byte count
- FIFO_DEPTH, 16, FIFO entries (power of 2, >= 2*BURST_BEATS)

Ports:
- i_clk, input, 1, clock
- i_rst_n, input, 1, synchronous active-low reset
- i_start, input, 1, one-cycle pulse: latch base address and length, begin transfer
- i_base_addr, input, ADDR_WIDTH, host start byte address (16-byte aligned)
- i_xfer_len, input, XFER_WIDTH, total bytes (multiple of 16, nonzero)
- o_busy, output, 1, transfer in progress
- o_xfer_done, output, 1, one-cycle pulse when the last burst completes
- i_user_data_valid, input, 1, user beat valid
- i_user_data, input, DATA_WIDTH, user beat
- o_user_data_rdy, output, 1, beat accepted when valid && rdy
- o_dma_data_avail, output, 1, burst ready for the arbitrator
- o_dma_wr_addr, output, ADDR_WIDTH, host byte address of the current burst
- o_dma_wr_len, output, DMA_LEN, beats in the current burst
- i_dma_data_rd, input, 1, pop one beat
- o_dma_data, output, DATA_WIDTH, FIFO head (first-word fall-through)
- i_dma_done, input, 1, current burst fully sent

Behaviour:
- Clocking and reset: i_clk is the only clock. Reset is synchronous, active-low, on i_rst_n.
- Reset values: all outputs 0. FIFO empty. State IDLE. Internal counters 0.
- Latching on start: i_start in IDLE latches addr=i_base_addr and rem_beats=i_xfer_len>>4, and clears acc_beats. Next state FILL, o_busy=1.
- Start outside IDLE: ignored.
- Zero length: i_start with i_xfer_len=0 goes straight to o_xfer_done pulse next cycle and stays IDLE.
- Burst sizing: burst_len = min(BURST_BEATS, rem_beats), registered on entry to FILL.
- User side: o_user_data_rdy = busy && FIFO not full && acc_beats < total_beats. Each accepted beat increments acc_beats. Beats offered in IDLE are not accepted.
- State machine:
  - FILL: when fifo_count >= burst_len, go to AVAIL. o_dma_data_avail=1, o_dma_wr_addr=addr, o_dma_wr_len=burst_len, all registered with their transition.
  - AVAIL: each i_dma_data_rd pops one beat, counted in rd_cnt. Reads beyond burst_len or with an empty FIFO are ignored (no pop, no counter change). o_dma_data_avail stays high until i_dma_done.
  - On i_dma_done in AVAIL: o_dma_data_avail=0, addr += burst_len*16 (modulo 2^ADDR_WIDTH), rem_beats -= burst_len, rd_cnt=0.
  - If the new rem_beats is 0: pulse o_xfer_done, o_busy=0, go IDLE. Otherwise go FILL.
  - i_dma_data_rd and i_dma_done in the same cycle: the pop is applied, then done is processed.
- Concurrency: FIFO push and pop in the same cycle leave the count unchanged. The user stream continues filling the FIFO during AVAIL.
- Latency: minimum 1 cycle from fifo_count reaching burst_len to o_dma_data_avail rising.
- Reset mid-operation: aborts the transfer and flushes the FIFO. No o_xfer_done pulse.

Test Plan:
- Single full burst: base=0x1000, len=128, 8 beats streamed back-to-back. Required: avail rises with addr=0x1000, len=8; 8 reads return beats in order; done gives o_xfer_done 1 cycle later and busy=0.
- Multi-burst with tail: base=0x2000, len=400 (25 beats). Required: bursts at 0x2000/8, 0x2080/8, 0x2100/8, 0x2180/1; then o_xfer_done; rdy drops after beat 25.
- Backpressure: len=256, rd withheld until FIFO full (16). Required: rdy=0 at count 16; no data loss; second burst avail asserts immediately after the first done.
- Extra reads: 10 rd pulses on an 8-beat burst. Required: exactly 8 pops; FIFO count unaffected by the last 2.
- Mid-burst reset: i_rst_n=0 after 3 reads. Required: all outputs 0 next cycle, FIFO empty, and a new i_start runs a clean transfer.
- Start while busy: second i_start with different base. Required: ignored; addresses follow the first base.
